sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 16 +
 rtl/sram_arb_grant.sv | 31 +++
 rtl/sram_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM encoding, port count
// and the default strobe length.
package sram_arb_pkg;

  localparam int NUM_PORTS       = 2;
  localparam int WAIT_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/sram_arb_grant.sv
// Grant selection for two requesters. Define SRAM_ARB_RR_EN for round-robin
// between simultaneous requests; otherwise port 0 has fixed priority.
module sram_arb_grant
  import sram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last,
  output logic [NUM_PORTS-1:0] grant
);

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    grant = req;
    // On contention, favour the port that was not served most recently.
    if (req[0] && req[1]) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end
`else
  logic last_unused;
  assign last_unused = last;

  always_comb begin
    grant = req;
    if (req[0] && req[1]) begin
      grant = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter onto a 16-bit asynchronous SRAM; each 32-bit word access is
// split into upper then lower halfword. Arbitration mode set by SRAM_ARB_RR_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [17:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [17:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p0_ack,
  output logic        p1_ack,
  output logic        p0_done,
  output logic        p1_done,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [18:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  state_t      state;
  logic [1:0]  grant;
  logic        last;
  logic        owner;
  logic        half;
  logic        we_q;
  logic        dq_oe;
  logic [3:0]  cnt;
  logic [17:0] addr_q;
  logic [31:0] wdata_q;
  logic [15:0] rd_hi;
  logic        strobe_last;

  sram_arb_grant u_grant (
    .req   ({p1_req, p0_req}),
    .last  (last),
    .grant (grant)
  );

  assign strobe_last = (state == STROBE) && (cnt == 4'(WAIT_CYCLES - 1));
  assign busy        = (state != IDLE);
  assign SRAM_ADDR   = {addr_q, half};
  assign SRAM_DQ     = dq_oe ? (half ? wdata_q[15:0] : wdata_q[31:16]) : 16'hzzzz;
  assign SRAM_CE_N   = 1'b0;
  assign SRAM_UB_N   = 1'b0;
  assign SRAM_LB_N   = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      half      <= 1'b0;
      we_q      <= 1'b0;
      dq_oe     <= 1'b0;
      cnt       <= '0;
      addr_q    <= '0;
      rdata     <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_done   <= 1'b0;
      p1_done   <= 1'b0;
    end else begin
      p0_ack  <= 1'b0;
      p1_ack  <= 1'b0;
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant) begin
            owner  <= grant[1];
            last   <= grant[1];
            we_q   <= grant[1] ? p1_we : p0_we;
            dq_oe  <= grant[1] ? p1_we : p0_we;
            addr_q <= grant[1] ? p1_addr : p0_addr;
            p0_ack <= grant[0];
            p1_ack <= grant[1];
            half   <= 1'b0;
            state  <= SETUP;
          end
        end
        SETUP: begin
          cnt       <= '0;
          SRAM_WE_N <= ~we_q;
          SRAM_OE_N <= we_q;
          state     <= STROBE;
        end
        STROBE: begin
          if (strobe_last) begin
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            if (!we_q && half) begin
              rdata <= {rd_hi, SRAM_DQ};
            end
            state <= HOLD;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HOLD: begin
          if (!half) begin
            half  <= 1'b1;
            state <= SETUP;
          end else begin
            dq_oe <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          p0_done <= ~owner;
          p1_done <= owner;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Upper read half is staged so rdata only changes once the whole word is in.
  always_ff @(posedge clk) begin
    if (state == IDLE && |grant) begin
      wdata_q <= grant[1] ? p1_wdata : p0_wdata;
    end
    if (strobe_last && !we_q && !half) begin
      rd_hi <= SRAM_DQ;
    end
  end

endmodule
